// File: rtl/raw_serial_pkg.sv
// Shared types and constants for the raw serial receiver.
// Build option: RAW_SERIAL_RX_PARITY_EN adds an even-parity bit and a PARITY state.
package raw_serial_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 104;
    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RAW_SERIAL_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/raw_serial_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Flops reset high so an idle line never looks like a start bit.
module raw_serial_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/raw_serial_rx.sv
// 8N1 serial receiver with a one-byte holding register and drop-on-full.
// Build option: RAW_SERIAL_RX_PARITY_EN enables even parity checking.
module raw_serial_rx
    import raw_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam logic [7:0] HALF = 8'(CLKS_PER_BIT / 2);
    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic       rxs;
    rx_state_e  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic       done, ferr_d, perr_d;
`ifdef RAW_SERIAL_RX_PARITY_EN
    logic       par_q, par_d;
`endif

    raw_serial_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (rxs)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        done    = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
`ifdef RAW_SERIAL_RX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rxs) state_d = START;
            end
            START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    sh_d  = {rxs, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
`ifdef RAW_SERIAL_RX_PARITY_EN
                    if (bit_q == LAST_BIT) state_d = PARITY;
`else
                    if (bit_q == LAST_BIT) state_d = STOP;
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`ifdef RAW_SERIAL_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    par_d   = rxs;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
`ifdef RAW_SERIAL_RX_PARITY_EN
                    perr_d = ^{sh_q, par_q};
`endif
                    // a low stop bit means the line may be in break; wait it out
                    if (!rxs) begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end else begin
                        done    = !perr_d;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT_HIGH: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
`ifdef RAW_SERIAL_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
`ifdef RAW_SERIAL_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    logic blocked;
    assign blocked = rx_valid && !rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_d;
            overrun   <= done && blocked;
            if (done && !blocked) begin
                rx_data  <= sh_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef RAW_SERIAL_RX_PARITY_EN
    logic perr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perr_q <= 1'b0;
        else        perr_q <= perr_d;
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/raw_serial_rx.md
RAW_SERIAL_RX -- requirements
Module: raw_serial_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, SHALL set clk cycles per serial bit; legal range 8..255.
REQ-002 clk  input  1  SHALL be the single system clock; all state changes occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 rxd  input  1  SHALL be the asynchronous serial line; idles high.
REQ-005 rx_data  output  8  SHALL hold the received byte, valid while rx_valid=1.
REQ-006 rx_valid  output  1  SHALL indicate that a byte is held.
REQ-007 rx_ready  input  1  SHALL be the consumer accept; a transfer occurs on a cycle with rx_valid=1 and rx_ready=1.
REQ-008 frame_err  output  1  SHALL pulse for one cycle when the stop bit is sampled low.
REQ-009 overrun  output  1  SHALL pulse for one cycle when a completed byte is dropped.
REQ-010 parity_err  output  1  SHALL pulse for one cycle on a parity mismatch (see Configuration).

Function
REQ-011 rxd SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rxs.
REQ-012 Frame format SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE -> START SHALL occur when rxs=0; the bit counter clears to 0.
REQ-015 In START, at count CLKS_PER_BIT/2 (integer division) the FSM SHALL resample: rxs=0 -> DATA with the counter cleared; rxs=1 -> IDLE (glitch rejected, no flag).
REQ-016 In DATA, each bit SHALL be sampled when the counter reaches CLKS_PER_BIT-1 (mid-bit), the counter then clears; after bit index 7 -> STOP.
REQ-017 In STOP, the sample at CLKS_PER_BIT-1 with rxs=1 SHALL complete the byte and go to IDLE; with rxs=0 it SHALL pulse frame_err, discard the byte, and go to WAIT_HIGH.
REQ-018 WAIT_HIGH -> IDLE SHALL occur on the first cycle with rxs=1 (break or stuck-low lines do not retrigger).
REQ-019 A completed byte SHALL load rx_data and set rx_valid on the cycle after the stop sample.
REQ-020 rx_valid SHALL stay 1 and rx_data stable until a transfer; rx_valid then clears on the next cycle unless a new byte loads.
REQ-021 A byte that completes while rx_valid=1 and rx_ready=0 SHALL be dropped: old data is kept and overrun pulses.
REQ-022 A byte that completes in the same cycle as a transfer SHALL load, rx_valid SHALL stay 1, and no overrun occurs.
REQ-023 Reception SHALL never stall on the consumer.
REQ-024 Counter width SHALL be 8 bits and SHALL never wrap within a bit period.

Reset
REQ-025 While rst_n=0, the block SHALL force: FSM=IDLE, counters=0, synchronizer flops=1, rx_data=0, rx_valid=0, frame_err=0, overrun=0, parity_err=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no flags raised; after release, reception SHALL start on the next falling edge.

Configuration
REQ-027 With macro RAW_SERIAL_RX_PARITY_EN defined, the frame SHALL carry an even-parity bit between bit 7 and stop, sampled via a PARITY state.
REQ-028 With parity enabled, a mismatch SHALL pulse parity_err together with the stop result and SHALL discard the byte; frame_err has priority only for routing to WAIT_HIGH.
REQ-029 Without the macro, the frame SHALL be 8N1, the PARITY state SHALL be absent, and parity_err SHALL be tied to 0.

Structure
REQ-030 Package raw_serial_pkg SHALL hold the FSM state enum, DEFAULT_CLKS_PER_BIT=104, and DATA_BITS=8.
REQ-031 The synchronizer SHALL be the sub-module raw_serial_sync (2 flops, reset value 1).

Verification
REQ-032 Verification SHALL cover: 0x41 sent at 104 clk/bit with rx_ready=1 -> rx_valid pulses once with rx_data=0x41, about 2+52+9*104 cycles after the start edge.
REQ-033 Verification SHALL cover: a 20-cycle low glitch on an idle line -> no rx_valid, no flags, FSM back in IDLE.
REQ-034 Verification SHALL cover: 0x55 sent with the stop bit forced 0, line held low 300 cycles -> one frame_err pulse, no rx_valid; then 0x0F -> rx_data=0x0F.
REQ-035 Verification SHALL cover: 0x11 then 0x22 back-to-back with rx_ready=0 -> rx_data=0x11, one overrun pulse; 0x33 completing in the rx_ready=1 cycle -> rx_data=0x33, no overrun.
REQ-036 Verification SHALL cover: rst_n pulsed low during bit 4 of 0xA5 -> no output or flags; the next frame 0x3C is received correctly.
REQ-037 Verification SHALL cover, with RAW_SERIAL_RX_PARITY_EN: 0x07 with parity bit 0 -> parity_err pulse, no rx_valid; with parity bit 1 -> rx_data=0x07.
